// File: rtl/key_loader_pkg.sv
// Shared types and constants for the serial key loader of the locked c432 core.
package key_loader_pkg;

  // Default key width: four mux keys plus four XOR keys.
  localparam int KEY_W_DEF = 8;

  // Key field layout as applied to the core.
  localparam int P_LSB = 0;  // p1..p4 mux keys
  localparam int P_MSB = 3;
  localparam int X_LSB = 4;  // X_1..X_4 XOR keys
  localparam int X_MSB = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    LOCKED = 2'd2,
    ERROR  = 2'd3
  } state_t;

endpackage

// File: rtl/key_loader_if.sv
// Key-source to loader bus: load request, serial handshake and key/status outputs.
interface key_loader_if
  import key_loader_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF
);

  logic             load_start;
  logic             key_valid;
  logic             key_bit;
  logic             key_accept;
  logic [KEY_W-1:0] key_out;
  logic             key_locked;
  logic             busy;
  logic             err;

  // The key source drives the serial stream and observes loader status.
  modport master (
    output load_start, key_valid, key_bit,
    input  key_accept, key_out, key_locked, busy, err
  );

  // The loader consumes the stream and drives the key and status.
  modport slave (
    input  load_start, key_valid, key_bit,
    output key_accept, key_out, key_locked, busy, err
  );

endinterface

// File: rtl/key_shift_reg.sv
// Serial-in key register written by bit index, with running parity of the bits taken.
module key_shift_reg #(
  parameter int KEY_W = 8,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic [IDX_W-1:0] idx,
  output logic [KEY_W-1:0] data,
  output logic             parity
);

  logic [KEY_W-1:0] data_reg;
  logic [KEY_W-1:0] data_next;
  logic             parity_reg;
  logic             parity_next;

  // Per-bit next value: clear wins, otherwise only the addressed bit loads.
  generate
    for (genvar gi = 0; gi < KEY_W; gi++) begin : g_bit
      assign data_next[gi] = clr ? 1'b0 :
                             (shift_en && (idx == IDX_W'(gi))) ? bit_in :
                             data_reg[gi];
    end
  endgenerate

  // Parity folds in every accepted data bit so the check is one XOR away.
  assign parity_next = clr ? 1'b0 : (shift_en ? (parity_reg ^ bit_in) : parity_reg);

  // Register the key bits and parity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg   <= '0;
      parity_reg <= 1'b0;
    end else begin
      data_reg   <= data_next;
      parity_reg <= parity_next;
    end
  end

  assign data   = data_reg;
  assign parity = parity_reg;

endmodule

// File: rtl/key_loader.sv
// Key loader FSM: accepts a serial key plus even parity and applies it only once verified.
module key_loader
  import key_loader_pkg::*;
#(
  parameter int KEY_W   = KEY_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  key_loader_if.slave  bus
);

  localparam int CNT_W = $clog2(KEY_W + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [TMO_W-1:0] timeout_reg, timeout_next;
  logic             clr;
  logic             shift_en;
  logic             xfer;
  logic [KEY_W-1:0] sr_data;
  logic             sr_parity;

  // A bit moves only while the loader advertises readiness, so stray
  // key_valid outside SHIFT has no effect.
  assign xfer = bus.key_valid && (state_reg == SHIFT);

  key_shift_reg #(
    .KEY_W (KEY_W),
    .IDX_W (CNT_W)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .shift_en (shift_en),
    .bit_in   (bus.key_bit),
    .idx      (count_reg),
    .data     (sr_data),
    .parity   (sr_parity)
  );

  // State and counter registers; reset drops any key immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      timeout_reg <= '0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      timeout_reg <= timeout_next;
    end
  end

  // Next state, counter updates and shift register controls.
  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    timeout_next = timeout_reg;
    clr          = 1'b0;
    shift_en     = 1'b0;
    case (state_reg)
      SHIFT: begin
        if (bus.load_start) begin
          // Restart; a coincident bit is dropped along with the partial key.
          count_next   = '0;
          timeout_next = '0;
          clr          = 1'b1;
        end else if (xfer) begin
          timeout_next = '0;
          if (count_reg < CNT_W'(KEY_W)) begin
            shift_en   = 1'b1;
            count_next = count_reg + 1'b1;
          end else if (sr_parity ^ bus.key_bit) begin
            state_next = ERROR;
          end else begin
            state_next = LOCKED;
          end
        end else begin
          if (timeout_reg < TMO_W'(TIMEOUT)) begin
            timeout_next = timeout_reg + 1'b1;
          end
          // This idle cycle is the TIMEOUT-th in a row.
          if (timeout_reg >= TMO_W'(TIMEOUT - 1)) begin
            state_next = ERROR;
          end
        end
      end
      default: begin
        // IDLE, LOCKED and ERROR hold until a new load is requested.
        if (bus.load_start) begin
          state_next   = SHIFT;
          count_next   = '0;
          timeout_next = '0;
          clr          = 1'b1;
        end
      end
    endcase
  end

  // Outputs decode from state only; the key is gated so partial data never leaks.
  always_comb begin
    bus.key_accept = (state_reg == SHIFT);
    bus.busy       = (state_reg == SHIFT);
    bus.key_locked = (state_reg == LOCKED);
    bus.err        = (state_reg == ERROR);
    bus.key_out    = (state_reg == LOCKED) ? sr_data : '0;
  end

endmodule

// File: tb/tb_key_loader.sv
// Directed bench for key_loader: good/bad parity, timeout, restart, async reset.
module tb_key_loader;
  import key_loader_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  key_loader_if #(.KEY_W(8)) bus ();

  key_loader #(.KEY_W(8), .TIMEOUT(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts, prints one line, flags mismatches.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.load_start = 1'b1;
    tick(1);
    bus.load_start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bus.key_valid = 1'b1;
    bus.key_bit   = b;
    tick(1);
    bus.key_valid = 1'b0;
    bus.key_bit   = 1'b0;
  endtask

  task automatic send_key(input logic [7:0] k, input logic par);
    for (int i = 0; i < 8; i++) send_bit(k[i]);
    send_bit(par);
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] ko, input logic lk,
                               input logic bsy, input logic ac, input logic er);
    check({tag, ".key_out"},    {24'd0, bus.key_out}, {24'd0, ko});
    check({tag, ".key_locked"}, {31'd0, bus.key_locked}, {31'd0, lk});
    check({tag, ".busy"},       {31'd0, bus.busy}, {31'd0, bsy});
    check({tag, ".key_accept"}, {31'd0, bus.key_accept}, {31'd0, ac});
    check({tag, ".err"},        {31'd0, bus.err}, {31'd0, er});
  endtask

  initial begin
    logic [7:0] ko;
    n_checks       = 0;
    n_errors       = 0;
    rst            = 1'b1;
    bus.load_start = 1'b0;
    bus.key_valid  = 1'b0;
    bus.key_bit    = 1'b0;

    // Reset state and no self-start after release.
    tick(3);
    check_outputs("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick(4);
    check_outputs("idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Stray key_valid in IDLE is ignored.
    bus.key_valid = 1'b1;
    bus.key_bit   = 1'b1;
    tick(3);
    bus.key_valid = 1'b0;
    check_outputs("idle_valid", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Good load of A5, then it persists.
    pulse_start();
    check_outputs("start1", 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    send_key(8'hA5, 1'b0);
    check_outputs("a5_good", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    ko = bus.key_out;
    check("a5.p_field", {28'd0, ko[P_MSB:P_LSB]}, 32'h5);
    check("a5.x_field", {28'd0, ko[X_MSB:X_LSB]}, 32'hA);
    tick(5);
    check_outputs("a5_hold", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reload from LOCKED: key withdrawn at once, then 3C applied.
    pulse_start();
    check_outputs("reload", 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    send_key(8'h3C, 1'b0);
    check_outputs("3c_good", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);

    // Bad parity.
    pulse_start();
    send_key(8'hA5, 1'b1);
    check_outputs("a5_badpar", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(4);
    check_outputs("err_hold", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Timeout: 3 bits then silence; 254 idle cycles still SHIFT, 255th errors.
    pulse_start();
    check("tmo.err_cleared", {31'd0, bus.err}, 32'd0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    tick(254);
    check_outputs("tmo_254", 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(1);
    check_outputs("tmo_255", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Gaps shorter than the timeout are tolerated; each bit restarts the count.
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      send_bit(i[0] ? 1'b1 : 1'b0);
      tick(200);
    end
    send_bit(1'b0);
    check_outputs("gap_aa", 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0);

    // Async reset mid-SHIFT after 5 bits.
    pulse_start();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    check("mid.busy", {31'd0, bus.busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_outputs("rst_shift", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    rst = 1'b0;
    tick(2);
    check_outputs("post_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse_start();
    send_key(8'hFF, 1'b0);
    check_outputs("ff_good", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);

    // Async reset while LOCKED drops the key without a clock edge.
    #3 rst = 1'b1;
    #1;
    check_outputs("rst_locked", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    rst = 1'b0;
    tick(1);

    // Restart coincident with the 4th transfer discards that bit.
    pulse_start();
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    bus.load_start = 1'b1;
    send_bit(1'b1);
    bus.load_start = 1'b0;
    check_outputs("restart", 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    send_key(8'h5A, 1'b0);
    check_outputs("5a_good", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
